// File: rtl/md_unit_e.sv
// E-stage multiply/divide unit: multi-cycle mult/multu/div/divu with Busy,
// single-cycle mthi/mtlo, and the architectural HI/LO registers.
module md_unit_e #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   input  logic [2:0]  MDop,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned W    = 32;
   localparam int unsigned CW   = 8;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    res_hi_q, res_lo_q;
   logic [W-1:0]    hi_q, lo_q;
   logic            busy_q;
   logic            zero_q;

   logic [2*W-1:0]  res_d;
   logic [CW-1:0]   cnt_d;
   logic            zero_d;
   logic            go_d;
   logic signed [2*W-1:0] a_sx, b_sx;
   logic [W-1:0]    quo_s, rem_s;

   // Result of the operation presented this cycle, captured at issue.
   always_comb begin
      res_d  = '0;
      cnt_d  = '0;
      zero_d = 1'b0;
      go_d   = 1'b0;
      a_sx   = {{W{SrcA[W-1]}}, SrcA};
      b_sx   = {{W{SrcB[W-1]}}, SrcB};
      quo_s  = '0;
      rem_s  = '0;
      // Guard divisor 0 and the single overflowing signed quotient explicitly.
      if (SrcB == '0) begin
         quo_s = '0;
         rem_s = '0;
      end else if (SrcA == 32'h8000_0000 && SrcB == 32'hFFFF_FFFF) begin
         quo_s = 32'h8000_0000;
         rem_s = '0;
      end else begin
         quo_s = W'($signed(SrcA) / $signed(SrcB));
         rem_s = W'($signed(SrcA) % $signed(SrcB));
      end
      case (MDop)
         OP_MULT: begin
            res_d = 64'(a_sx * b_sx);
            cnt_d = CW'(MULT_CYCLES);
            go_d  = 1'b1;
         end
         OP_MULTU: begin
            res_d = 64'({32'd0, SrcA} * {32'd0, SrcB});
            cnt_d = CW'(MULT_CYCLES);
            go_d  = 1'b1;
         end
         OP_DIV: begin
            res_d  = {rem_s, quo_s};
            cnt_d  = CW'(DIV_CYCLES);
            zero_d = (SrcB == '0);
            go_d   = 1'b1;
         end
         OP_DIVU: begin
            if (SrcB != '0) res_d = {SrcA % SrcB, SrcA / SrcB};
            cnt_d  = CW'(DIV_CYCLES);
            zero_d = (SrcB == '0);
            go_d   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Start) begin
                  if (go_d) begin
                     res_hi_q <= res_d[2*W-1:W];
                     res_lo_q <= res_d[W-1:0];
                     cnt_q    <= cnt_d;
                     zero_q   <= zero_d;
                     busy_q   <= 1'b1;
                     state_q  <= RUN;
                  end else if (MDop == OP_MTHI) begin
                     hi_q <= SrcA;
                  end else if (MDop == OP_MTLO) begin
                     lo_q <= SrcA;
                  end
               end
            end
            RUN: begin
               // Start is ignored here; the running operation owns the unit.
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                  if (!zero_q) begin
                     hi_q <= res_hi_q;
                     lo_q <= res_lo_q;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit_e.sv
// Randomized self-checking bench for md_unit_e against a plain-arithmetic model.
module tb_md_unit_e;

   localparam int unsigned MULT_N = 5;
   localparam int unsigned DIV_N  = 10;

   logic        clk;
   logic        reset;
   logic [31:0] SrcA, SrcB;
   logic [2:0]  MDop;
   logic        Start;
   logic        Busy;
   logic [31:0] HI, LO;

   int n_tests;
   int n_fail;

   logic [31:0] m_hi, m_lo;

   md_unit_e #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB),
      .MDop(MDop), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Architectural effect of one operation, computed with 64-bit arithmetic.
   function automatic int model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
      longint          sa, sb, p, q, r;
      longint unsigned pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; return MULT_N; end
         3'd2: begin pu = {32'd0, a} * {32'd0, b}; hi = pu[63:32]; lo = pu[31:0]; return MULT_N; end
         3'd3: begin
            if (b != 0) begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
            return DIV_N;
         end
         3'd4: begin
            if (b != 0) begin hi = a % b; lo = a / b; end
            return DIV_N;
         end
         3'd5: begin hi = a; return 0; end
         3'd6: begin lo = a; return 0; end
         default: return 0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op; optionally poke a second Start mid-run, which must be ignored.
   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic st, input bit intrude,
                        input logic [2:0] iop, input logic [31:0] ia);
      logic [31:0] old_hi, old_lo;
      int n;
      old_hi = m_hi;
      old_lo = m_lo;
      n = st ? model(op, a, b, m_hi, m_lo) : 0;
      SrcA = a; SrcB = b; MDop = op; Start = st;
      step();
      Start = 1'b0; MDop = 3'd0;
      for (int i = 1; i <= n; i++) begin
         chk({tag, " busy"}, {31'd0, Busy}, 32'd1);
         if (i == 1) begin
            chk({tag, " hi_hold"}, HI, old_hi);
            chk({tag, " lo_hold"}, LO, old_lo);
         end
         if (intrude && i == 2) begin
            SrcA = ia; SrcB = 32'd3; MDop = iop; Start = 1'b1;
         end
         step();
         Start = 1'b0; MDop = 3'd0;
      end
      chk({tag, " busy_lo"}, {31'd0, Busy}, 32'd0);
      chk({tag, " hi"}, HI, m_hi);
      chk({tag, " lo"}, LO, m_lo);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      n_tests = 0;
      n_fail  = 0;
      m_hi = '0; m_lo = '0;
      reset = 1'b0; SrcA = '0; SrcB = '0; MDop = '0; Start = 1'b0;
      #12;
      chk("rst busy", {31'd0, Busy}, 32'd0);
      chk("rst hi", HI, 32'd0);
      chk("rst lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // Reset in the 3rd busy cycle of a mult discards it.
      SrcA = 32'd9; SrcB = 32'd9; MDop = 3'd1; Start = 1'b1;
      step();
      Start = 1'b0; MDop = 3'd0;
      step(); step();
      chk("midrst busy_pre", {31'd0, Busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("midrst busy", {31'd0, Busy}, 32'd0);
      chk("midrst hi", HI, 32'd0);
      chk("midrst lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("midrst idle busy", {31'd0, Busy}, 32'd0);
      chk("midrst idle hi", HI, 32'd0);
      chk("midrst idle lo", LO, 32'd0);

      do_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 3'd0, '0);
      chk("mult hi_const", HI, 32'hFFFF_FFFF);
      chk("mult lo_const", LO, 32'hFFFF_FFFA);
      do_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 3'd0, '0);
      chk("multu hi_const", HI, 32'h0000_0002);
      chk("multu lo_const", LO, 32'hFFFF_FFFA);
      do_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 3'd0, '0);
      chk("div lo_const", LO, 32'hFFFF_FFFD);
      chk("div hi_const", HI, 32'hFFFF_FFFF);
      do_op("mthi", 3'd5, 32'h11, 32'd0, 1'b1, 1'b0, 3'd0, '0);
      do_op("mtlo", 3'd6, 32'h22, 32'd0, 1'b1, 1'b0, 3'd0, '0);
      do_op("divu0", 3'd4, 32'd7, 32'd0, 1'b1, 1'b0, 3'd0, '0);
      chk("divu0 hi_const", HI, 32'h11);
      chk("divu0 lo_const", LO, 32'h22);
      do_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'd0, '0);
      chk("divovf lo_const", LO, 32'h8000_0000);
      chk("divovf hi_const", HI, 32'h0);
      do_op("mtlo2", 3'd6, 32'h1234, 32'd0, 1'b1, 1'b0, 3'd0, '0);
      chk("mtlo2 lo_const", LO, 32'h1234);
      do_op("div_intr", 3'd3, 32'd100, 32'd7, 1'b1, 1'b1, 3'd1, 32'h5555);
      do_op("div_intr_mt", 3'd4, 32'd1000, 32'd9, 1'b1, 1'b1, 3'd6, 32'hDEAD);
      do_op("nostart", 3'd1, 32'd5, 32'd5, 1'b0, 1'b0, 3'd0, '0);
      do_op("none", 3'd0, 32'd5, 32'd5, 1'b1, 1'b0, 3'd0, '0);
      do_op("resv", 3'd7, 32'd5, 32'd5, 1'b1, 1'b0, 3'd0, '0);

      for (int k = 0; k < 60; k++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom();
         b  = $urandom();
         case ($urandom_range(0, 7))
            0: b = '0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = 32'($urandom_range(1, 16));
            default: ;
         endcase
         do_op($sformatf("rnd%0d op%0d", k, op), op, a, b, 1'($urandom_range(0, 7) != 0),
               bit'($urandom_range(0, 3) == 0), 3'($urandom_range(1, 6)), $urandom());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/md_unit_e.md
Name: md_unit_E

Overview:
Multiply/divide unit in the E stage, beside alu_E and fed by the same forwarded SrcA/SrcB operands. Runs mult/multu/div/divu as multi-cycle operations with a Busy flag, and applies mthi/mtlo as single-cycle writes. Holds the architectural HI/LO registers. The M-stage mfhi/mflo path reads HI/LO directly. The hazard unit stalls D on Start or Busy when an MD instruction is in D.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for mult/multu (1..255)
DIV_CYCLES, 10, cycles Busy stays high for div/divu (1..255)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
SrcA  input  32  rs operand (forwarded)
SrcB  input  32  rt operand (forwarded)
MDop  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
Start  input  1  qualifies MDop this cycle; driven low by controller on E-stage bubble or exception flush
Busy  output  1  multi-cycle operation in progress
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (reset==0, async): state IDLE, counter 0, Busy=0, HI=0, LO=0, internal result regs 0; any operation in flight is discarded.
- States: IDLE, RUN; 8-bit down-counter cnt; 64-bit pending result {resHI,resLO}.
- IDLE, Start=1, MDop in 1..4 on edge T:
  - compute result from SrcA/SrcB at T and store it in resHI/resLO;
  - load cnt with MULT_CYCLES (1,2) or DIV_CYCLES (3,4); go to RUN.
  - Busy=1 for exactly cnt cycles after edge T.
- RUN: decrement cnt each edge. On the edge where cnt==1: HI<=resHI, LO<=resLO, Busy<=0, go to IDLE. New HI/LO are visible in the first cycle Busy is low.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 -> 64; HI=[63:32], LO=[31:0].
  - div: LO=signed quotient truncated toward zero; HI=remainder, sign follows dividend (SrcA).
  - div overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divisor 0 (div/divu): full DIV_CYCLES Busy, then HI/LO keep their previous values; no exception raised.
- mthi/mtlo: IDLE with Start=1 -> HI<=SrcA (mthi) or LO<=SrcA (mtlo) on that edge; Busy stays 0.
- Start=1 while Busy=1 (controller error): ignored, running operation unaffected.
- Start=0 or MDop none/reserved: no state change.
- Outputs HI, LO and Busy are registered only; no combinational path from inputs.

Test Plan:
- Reset low mid-RUN (3rd cycle of mult): Busy, HI, LO go to 0 immediately; after release, IDLE with no later HI/LO write.
- mult SrcA=0xFFFFFFFE (-2), SrcB=3, Start pulse: Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with the same operands: HI=0x00000002, LO=0xFFFFFFFA after 5 Busy cycles.
- div SrcA=-7 (0xFFFFFFF9), SrcB=2: Busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu SrcA=7, SrcB=0 after HI=0x11, LO=0x22 loaded via mthi/mtlo: Busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- mtlo SrcA=0x1234 with Start, then mult issued while Busy from a prior div: LO=0x1234 the next cycle with Busy=0; the second Start is ignored and div result lands on schedule.
